// File: rtl/l2_bus_adapter.sv
// l2_bus_adapter: turns word-at-a-time L2 requests into single handshaked memory transactions.
// Optional macro BUS_L2_TIMEOUT_EN adds a BUSY-cycle watchdog that forces L2_ERROR.
package l2_bus_adapter_pkg;
  typedef enum logic [1:0] {
    L2_FREE   = 2'd0,
    L2_BUSY   = 2'd1,
    L2_ACCESS = 2'd2,
    L2_ERROR  = 2'd3
  } l2_state_t;
endpackage

module l2_bus_adapter
  import l2_bus_adapter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned WORD_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                l2REN,
  input  logic                l2WEN,
  input  logic [ADDR_W-1:0]   l2addr,
  input  logic [2*WORD_W-1:0] l2store,
  output logic [WORD_W-1:0]   l2load,
  output l2_state_t           l2state,
  output logic                mem_req,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  input  logic [WORD_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  input  logic                mem_err
);

  l2_state_t           state_q, state_d;
  logic                req_q, req_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   load_q, load_d;
  logic                req_any;
  logic                unused_bits;

  assign req_any     = l2REN | l2WEN;
  // Byte offset is implied by word alignment; timeout depth only matters with the watchdog.
  assign unused_bits = ^{l2addr[1:0], 1'(TIMEOUT_CYCLES)};

`ifdef BUS_L2_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;

  assign tmo_hit = (tmo_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    load_d  = load_q;
`ifdef BUS_L2_TIMEOUT_EN
    tmo_d   = (state_q == L2_BUSY) ? tmo_q + 1'b1 : '0;
`endif
    unique case (state_q)
      L2_FREE: begin
        if (req_any) begin
          state_d = L2_BUSY;
          req_d   = 1'b1;
          wen_d   = l2WEN;
          addr_d  = {l2addr[ADDR_W-1:2], 2'b00};
          wdata_d = l2addr[2] ? l2store[2*WORD_W-1:WORD_W] : l2store[WORD_W-1:0];
        end
      end
      L2_BUSY: begin
        if (mem_ready) begin
          req_d = 1'b0;
          // An aborted request still completes on the bus but reports nothing upstream.
          if (!req_any) begin
            state_d = L2_FREE;
          end else if (mem_err) begin
            state_d = L2_ERROR;
          end else begin
            state_d = L2_ACCESS;
            if (!wen_q) load_d = mem_rdata;
          end
        end
`ifdef BUS_L2_TIMEOUT_EN
        else if (tmo_hit) begin
          req_d   = 1'b0;
          state_d = L2_ERROR;
        end
`endif
      end
      L2_ACCESS: state_d = L2_FREE;
      L2_ERROR: begin
        if (!req_any) state_d = L2_FREE;
      end
      default: state_d = L2_FREE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= L2_FREE;
      req_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      load_q  <= load_d;
    end
  end

`ifdef BUS_L2_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign l2state   = state_q;
  assign l2load    = load_q;
  assign mem_req   = req_q;
  assign mem_wen   = wen_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_l2_bus_adapter.sv
// Scoreboard bench for l2_bus_adapter: directed spec cases, random transactions, reset,
// and the watchdog when BUS_L2_TIMEOUT_EN is defined.
module tb_l2_bus_adapter;
  import l2_bus_adapter_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        l2REN, l2WEN;
  logic [31:0] l2addr;
  logic [63:0] l2store;
  logic [31:0] l2load;
  l2_state_t   l2state;
  logic        mem_req, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, mem_err;

  l2_bus_adapter #(
    .ADDR_W        (32),
    .WORD_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .l2REN    (l2REN),
    .l2WEN    (l2WEN),
    .l2addr   (l2addr),
    .l2store  (l2store),
    .l2load   (l2load),
    .l2state  (l2state),
    .mem_req  (mem_req),
    .mem_wen  (mem_wen),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_err  (mem_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } exp_req_t;

  typedef struct {
    l2_state_t   st;
    logic [31:0] load;
  } exp_out_t;

  exp_req_t    req_q[$];
  exp_out_t    out_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] model_load;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: pairs each new memory request and each BUSY exit with the scoreboard.
  l2_state_t prev_st;
  logic      prev_req;
  exp_req_t  cur_req;
  exp_out_t  cur_out;

  initial begin
    prev_st  = L2_FREE;
    prev_req = 1'b0;
    cur_req  = '{32'h0, 1'b0, 32'h0};
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_st  = L2_FREE;
        prev_req = 1'b0;
      end else begin
        if (mem_req && !prev_req) begin
          n_checks++;
          if (req_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_req: got mem_req=1 expected no request at %0t", $time);
          end else begin
            cur_req = req_q.pop_front();
          end
        end
        if (mem_req) begin
          chk("mem_addr", 64'(mem_addr), 64'(cur_req.addr));
          chk("mem_wen", 64'(mem_wen), 64'(cur_req.wen));
          chk("mem_wdata", 64'(mem_wdata), 64'(cur_req.wdata));
        end
        if (prev_st == L2_BUSY && l2state != L2_BUSY) begin
          n_checks++;
          if (out_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_done: got state %0d expected BUSY at %0t", l2state, $time);
          end else begin
            cur_out = out_q.pop_front();
            chk("done_state", 64'(l2state), 64'(cur_out.st));
            if (cur_out.st != L2_ERROR) chk("l2load", 64'(l2load), 64'(cur_out.load));
          end
        end
        if (prev_st == L2_ACCESS) chk("access_1cyc", 64'(l2state), 64'(L2_FREE));
        prev_st  = l2state;
        prev_req = mem_req;
      end
    end
  end

  // kind: 0 = normal completion, 1 = mem_err, 2 = request dropped while BUSY.
  task automatic do_txn(input logic w, input logic r, input logic [31:0] a, input logic [63:0] s,
                        input int lat, input int kind, input logic [31:0] rd, input int hold);
    exp_req_t er;
    exp_out_t eo;
    er.addr  = {a[31:2], 2'b00};
    er.wen   = w;
    er.wdata = a[2] ? s[63:32] : s[31:0];
    req_q.push_back(er);
    if (kind == 1) begin
      eo = '{L2_ERROR, 32'h0};
    end else if (kind == 2) begin
      eo = '{L2_FREE, model_load};
    end else begin
      if (!w) model_load = rd;
      eo = '{L2_ACCESS, model_load};
    end
    out_q.push_back(eo);

    @(posedge CLK); #1;
    l2WEN = w; l2REN = r; l2addr = a; l2store = s;
    @(posedge CLK); #1;
    chk("req_latency", 64'(mem_req), 64'(1));
    l2addr  = $urandom;
    l2store = {$urandom, $urandom};
    if (kind == 2) begin
      l2WEN = 1'b0;
      l2REN = 1'b0;
    end
    repeat (lat) begin
      @(posedge CLK); #1;
    end
    mem_ready = 1'b1;
    mem_err   = (kind == 1);
    mem_rdata = rd;
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = $urandom;
    chk("req_drop", 64'(mem_req), 64'(0));
    if (kind == 1) begin
      repeat (hold) begin
        @(posedge CLK); #1;
        chk("err_held", 64'(l2state), 64'(L2_ERROR));
      end
      l2WEN = 1'b0;
      l2REN = 1'b0;
      @(posedge CLK); #1;
      chk("err_exit", 64'(l2state), 64'(L2_FREE));
    end else begin
      l2WEN = 1'b0;
      l2REN = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish by 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; l2REN = 1'b0; l2WEN = 1'b0; l2addr = '0; l2store = '0;
    mem_rdata = '0; mem_ready = 1'b0; mem_err = 1'b0;
    model_load = 32'h0;
    #2;
    chk("rst_state", 64'(l2state), 64'(L2_FREE));
    chk("rst_load", 64'(l2load), 64'(0));
    chk("rst_req", 64'({mem_req, mem_wen}), 64'(0));
    chk("rst_addr", 64'({mem_addr, mem_wdata}), 64'(0));
    @(posedge CLK); #1;
    RST = 1'b0;

    do_txn(1'b0, 1'b1, 32'h1004, 64'h0, 2, 0, 32'hDEADBEEF, 0);
    do_txn(1'b1, 1'b0, 32'h2000, 64'h11112222_33334444, 0, 0, 32'h0, 0);
    do_txn(1'b1, 1'b0, 32'h2004, 64'h11112222_33334444, 0, 0, 32'h0, 0);
    do_txn(1'b1, 1'b1, 32'h3000, 64'hAAAA5555_CAFEF00D, 1, 0, 32'h12345678, 0);
    do_txn(1'b0, 1'b1, 32'h4008, 64'h0, 3, 2, 32'h55555555, 0);
    do_txn(1'b0, 1'b1, 32'h500C, 64'h0, 1, 1, 32'h66666666, 2);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] rw;
      rw = 2'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      do_txn(rw[1], rw[0], $urandom, {$urandom, $urandom}, $urandom_range(0, 4),
             $urandom_range(0, 2), $urandom, $urandom_range(0, 3));
    end

`ifdef BUS_L2_TIMEOUT_EN
    begin
      int busy_cycles;
      req_q.push_back('{32'h6000, 1'b0, 32'h0});
      out_q.push_back('{L2_ERROR, 32'h0});
      @(posedge CLK); #1;
      l2REN = 1'b1; l2addr = 32'h6000; l2store = '0;
      busy_cycles = 0;
      for (int k = 0; k < 20; k++) begin
        @(posedge CLK); #1;
        if (mem_req) busy_cycles++;
        else break;
      end
      chk("tmo_cycles", 64'(busy_cycles), 64'(8));
      chk("tmo_state", 64'(l2state), 64'(L2_ERROR));
      mem_ready = 1'b1; mem_rdata = 32'hBADBAD00;
      @(posedge CLK); #1;
      mem_ready = 1'b0;
      chk("tmo_late_ready", 64'({l2state, mem_req}), 64'({L2_ERROR, 1'b0}));
      chk("tmo_load", 64'(l2load), 64'(model_load));
      l2REN = 1'b0;
      @(posedge CLK); #1;
      chk("tmo_exit", 64'(l2state), 64'(L2_FREE));
    end
`endif

    // Async reset while BUSY: outputs must clear before the next clock edge.
    @(posedge CLK); #1;
    l2REN = 1'b1; l2addr = 32'h7004; l2store = 64'hFFFF0000_FFFF0000;
    @(posedge CLK); #1;
    chk("rst_pre_req", 64'(mem_req), 64'(1));
    #2 RST = 1'b1;
    #1;
    chk("arst_req", 64'({mem_req, mem_wen}), 64'(0));
    chk("arst_state", 64'(l2state), 64'(L2_FREE));
    chk("arst_load", 64'(l2load), 64'(0));
    chk("arst_addr", 64'({mem_addr, mem_wdata}), 64'(0));
    @(posedge CLK); #1;
    l2REN = 1'b0;
    RST   = 1'b0;
    model_load = 32'h0;
    repeat (3) @(posedge CLK);

    chk("req_q_empty", 64'(req_q.size()), 64'(0));
    chk("out_q_empty", 64'(out_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
